mp_mem: RTL and testbench

MP_MEM -- requirements
Module: mp_mem

---
 rtl/mp_mem.sv | 126 ++++++++++++
 tb/tb_mp_mem.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_mem.sv
// Multi-port word memory with byte enables, per-address round-robin conflict
// arbitration, one-cycle read latency and out-of-range error strobes.
module mp_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 49152,
  parameter int NUM_PORTS  = 2,
  localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_PORTS-1:0]              valid,
  input  logic [NUM_PORTS-1:0]              op,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wr_data,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] wr_be,
  output logic [NUM_PORTS-1:0]              ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_PORTS-1:0]              rd_valid,
  output logic [NUM_PORTS-1:0]              err,
  output logic [PTR_W-1:0]                  dbg_rr_ptr
);

  // Handshake: a request on port p transfers at the rising clk edge where
  // valid[p] && ready[p]; a port refused (ready[p] = 0) keeps its request stable.

  localparam int BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0]           r_mem [MEM_DEPTH];
  logic [PTR_W-1:0]                r_rr_ptr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_rd_data;
  logic [NUM_PORTS-1:0]            r_rd_valid;
  logic [NUM_PORTS-1:0]            r_err;

  logic [ADDR_WIDTH-1:0] w_a [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_inr;
  logic [NUM_PORTS-1:0]  w_req;
  logic [NUM_PORTS-1:0]  w_grp_wr;
  logic [NUM_PORTS-1:0]  w_grp_oth;
  logic [NUM_PORTS-1:0]  w_earlier;
  logic [NUM_PORTS-1:0]  w_ready;
  logic [NUM_PORTS-1:0]  w_win;
  logic [NUM_PORTS-1:0]  w_acc;
  logic [PTR_W-1:0]      w_ptr_nxt;

  // Circular distance of a port from the round-robin pointer.
  function automatic int rr_dist(input int idx, input int ptr);
    return (idx - ptr + NUM_PORTS) % NUM_PORTS;
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_a[p]   = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      w_inr[p] = ({1'b0, w_a[p]} < (ADDR_WIDTH+1)'(MEM_DEPTH));
      w_req[p] = valid[p] & w_inr[p];
    end
  end

  // A conflicting group is every valid in-range port on one address, provided
  // the group holds a write; only its member closest to rr_ptr proceeds.
  always_comb begin
    w_grp_wr  = '0;
    w_grp_oth = '0;
    w_earlier = '0;
    w_ready   = '1;
    w_win     = '0;
    w_ptr_nxt = r_rr_ptr;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_grp_wr[p] = op[p];
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (q != p && w_req[q] && w_a[q] == w_a[p]) begin
          w_grp_oth[p] = 1'b1;
          if (op[q]) w_grp_wr[p] = 1'b1;
          if (rr_dist(q, int'(r_rr_ptr)) < rr_dist(p, int'(r_rr_ptr))) w_earlier[p] = 1'b1;
        end
      end
      if (w_req[p] && w_grp_wr[p] && w_grp_oth[p]) begin
        if (w_earlier[p]) w_ready[p] = 1'b0;
        else              w_win[p]   = 1'b1;
      end
    end
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (w_win[p]) w_ptr_nxt = PTR_W'((p + 1) % NUM_PORTS);
    end
  end

  assign ready = rstn ? w_ready : '0;
  assign w_acc = valid & ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr   <= '0;
      r_rd_valid <= '0;
      r_err      <= '0;
      r_rd_data  <= '0;
    end else begin
      r_rr_ptr <= w_ptr_nxt;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_rd_valid[p] <= w_acc[p] & ~op[p];
        r_err[p]      <= w_acc[p] & ~w_inr[p];
        if (w_acc[p] && !op[p]) begin
          r_rd_data[p*DATA_WIDTH +: DATA_WIDTH] <= w_inr[p] ? r_mem[w_a[p]] : '0;
        end
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rstn.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_acc[p] && op[p] && w_inr[p]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (wr_be[p*BE_W + b]) begin
            r_mem[w_a[p]][b*8 +: 8] <= wr_data[p*DATA_WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign err        = r_err;
  assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_mp_mem.sv
// Bench for mp_mem: directed vector table, reset corner sequences and a
// randomized phase checked against a group-level arbitration/memory model.
module tb_mp_mem;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int NP    = 2;
  localparam int DEPTH = 49152;
  localparam int BW    = DW / 8;

  logic               clk;
  logic               rstn;
  logic [NP-1:0]      valid;
  logic [NP-1:0]      op;
  logic [NP*AW-1:0]   addr;
  logic [NP*DW-1:0]   wr_data;
  logic [NP*BW-1:0]   wr_be;
  logic [NP-1:0]      ready;
  logic [NP*DW-1:0]   rd_data;
  logic [NP-1:0]      rd_valid;
  logic [NP-1:0]      err;
  logic               dbg_rr_ptr;

  mp_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .NUM_PORTS(NP)) dut (
    .clk(clk), .rstn(rstn), .valid(valid), .op(op), .addr(addr),
    .wr_data(wr_data), .wr_be(wr_be), .ready(ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .err(err), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int              n_chk = 0;
  int              n_err = 0;
  logic [DW-1:0]   exp_q[$];
  logic [DW-1:0]   m_mem [int];
  logic [DW-1:0]   m_last [NP];
  int              m_ptr;
  logic [NP-1:0]   m_rdy;
  logic [NP-1:0]   s_ready, s_rv, s_err;
  logic [NP*DW-1:0] s_rd;
  logic            s_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int p, input logic v, input logic o, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    valid[p]           = v;
    op[p]              = o;
    addr[p*AW +: AW]   = a;
    wr_data[p*DW +: DW] = d;
    wr_be[p*BW +: BW]  = be;
  endtask

  function automatic logic [AW-1:0] pa(input int p);
    return addr[p*AW +: AW];
  endfunction

  // ---------------- reference model ----------------
  // Each port's group = valid in-range ports sharing its address. A group with
  // two or more members and any write lets through only the member nearest the
  // pointer (circularly); the pointer moves past the lowest-index such winner.
  task automatic model_arb(output logic [NP-1:0] rdy, output int nptr);
    int best, cnt, win_min;
    bit anyw;
    rdy = '1;
    win_min = NP;
    for (int p = 0; p < NP; p++) begin
      if (valid[p] && int'(pa(p)) < DEPTH) begin
        best = -1; cnt = 0; anyw = 0;
        for (int q = 0; q < NP; q++) begin
          if (valid[q] && int'(pa(q)) < DEPTH && pa(q) == pa(p)) begin
            cnt++;
            if (op[q]) anyw = 1;
            if (best < 0 || ((q - m_ptr + NP) % NP) < ((best - m_ptr + NP) % NP)) best = q;
          end
        end
        if (cnt > 1 && anyw) begin
          rdy[p] = (p == best);
          if (best < win_min) win_min = best;
        end
      end
    end
    nptr = (win_min < NP) ? (win_min + 1) % NP : m_ptr;
  endtask

  // Entered just after a falling edge with inputs already driven.
  task automatic do_cycle();
    logic [NP-1:0] e_rv, e_err;
    logic [DW-1:0] w;
    int np, a;
    #1;
    model_arb(m_rdy, np);
    s_ready = ready;
    check("ready", 64'(ready), 64'(m_rdy));
    @(posedge clk);
    e_rv = '0;
    e_err = '0;
    for (int p = 0; p < NP; p++) begin
      a = int'(pa(p));
      if (valid[p] && m_rdy[p]) begin
        if (a >= DEPTH) e_err[p] = 1'b1;
        if (!op[p]) begin
          e_rv[p] = 1'b1;
          exp_q.push_back((a >= DEPTH) ? '0 : (m_mem.exists(a) ? m_mem[a] : '0));
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      a = int'(pa(p));
      if (valid[p] && m_rdy[p] && op[p] && a < DEPTH) begin
        w = m_mem.exists(a) ? m_mem[a] : '0;
        for (int b = 0; b < BW; b++)
          if (wr_be[p*BW + b]) w[b*8 +: 8] = wr_data[p*DW + b*8 +: 8];
        m_mem[a] = w;
      end
    end
    m_ptr = np;
    #1;
    s_rv = rd_valid; s_err = err; s_rd = rd_data; s_ptr = dbg_rr_ptr;
    check("rr_ptr", 64'(dbg_rr_ptr), 64'(m_ptr));
    check("rd_valid", 64'(rd_valid), 64'(e_rv));
    check("err", 64'(err), 64'(e_err));
    for (int p = 0; p < NP; p++) begin
      if (e_rv[p]) m_last[p] = exp_q.pop_front();
      check($sformatf("rd_data%0d", p), 64'(rd_data[p*DW +: DW]), 64'(m_last[p]));
    end
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]    v, o;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [BW-1:0] be0, be1;
    logic [1:0]    e_rdy;
    logic          e_ptr;
    logic [1:0]    e_rv, e_err;
    logic [DW-1:0] e_rd0, e_rd1;
  } vec_t;

  localparam int NT = 18;
  vec_t tbl [NT];
  logic [NP-1:0] pend;

  initial begin
    tbl[0]  = '{2'b01, 2'b01, 16'h0010, 16'h0000, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0, 2'b11, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[1]  = '{2'b01, 2'b00, 16'h0010, 16'h0000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b0, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{2'b10, 2'b10, 16'h0000, 16'h0010, 32'h0, 32'h000000AA, 4'h0, 4'h1, 2'b11, 1'b0, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0};
    tbl[3]  = '{2'b01, 2'b00, 16'h0010, 16'h0000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b0, 2'b01, 2'b00, 32'hDEADBEAA, 32'h0};
    tbl[4]  = '{2'b11, 2'b11, 16'h0020, 16'h0020, 32'h11111111, 32'h22222222, 4'hF, 4'hF, 2'b01, 1'b1, 2'b00, 2'b00, 32'hDEADBEAA, 32'h0};
    tbl[5]  = '{2'b10, 2'b10, 16'h0000, 16'h0020, 32'h0, 32'h22222222, 4'h0, 4'hF, 2'b11, 1'b1, 2'b00, 2'b00, 32'hDEADBEAA, 32'h0};
    tbl[6]  = '{2'b01, 2'b00, 16'h0020, 16'h0000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b1, 2'b01, 2'b00, 32'h22222222, 32'h0};
    tbl[7]  = '{2'b01, 2'b01, 16'h0030, 16'h0000, 32'h12345678, 32'h0, 4'hF, 4'h0, 2'b11, 1'b1, 2'b00, 2'b00, 32'h22222222, 32'h0};
    tbl[8]  = '{2'b11, 2'b00, 16'h0030, 16'h0030, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b1, 2'b11, 2'b00, 32'h12345678, 32'h12345678};
    tbl[9]  = '{2'b10, 2'b00, 16'h0000, 16'hC000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b1, 2'b10, 2'b10, 32'h12345678, 32'h0};
    tbl[10] = '{2'b11, 2'b11, 16'hC000, 16'hC000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 4'hF, 2'b11, 1'b1, 2'b00, 2'b11, 32'h12345678, 32'h0};
    tbl[11] = '{2'b11, 2'b11, 16'h0040, 16'h0040, 32'hAAAA0000, 32'h55550000, 4'hF, 4'hF, 2'b10, 1'b0, 2'b00, 2'b00, 32'h12345678, 32'h0};
    tbl[12] = '{2'b01, 2'b01, 16'h0040, 16'h0000, 32'hAAAA0000, 32'h0, 4'hF, 4'h0, 2'b11, 1'b0, 2'b00, 2'b00, 32'h12345678, 32'h0};
    tbl[13] = '{2'b11, 2'b10, 16'h0040, 16'h0040, 32'h0, 32'hBBBBBBBB, 4'h0, 4'hF, 2'b01, 1'b1, 2'b01, 2'b00, 32'hAAAA0000, 32'h0};
    tbl[14] = '{2'b11, 2'b10, 16'h0040, 16'h0040, 32'h0, 32'hBBBBBBBB, 4'h0, 4'hF, 2'b10, 1'b0, 2'b00, 2'b00, 32'hAAAA0000, 32'h0};
    tbl[15] = '{2'b01, 2'b00, 16'h0040, 16'h0000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 1'b0, 2'b01, 2'b00, 32'hBBBBBBBB, 32'h0};
    tbl[16] = '{2'b11, 2'b11, 16'h0050, 16'h0050, 32'h00005050, 32'h05050000, 4'hF, 4'hF, 2'b01, 1'b1, 2'b00, 2'b00, 32'hBBBBBBBB, 32'h0};
    tbl[17] = '{2'b10, 2'b10, 16'h0000, 16'h0050, 32'h0, 32'h05050000, 4'h0, 4'hF, 2'b11, 1'b1, 2'b00, 2'b00, 32'hBBBBBBBB, 32'h0};

    // Reset state, with requests presented to prove ready is forced low.
    rstn = 1'b0;
    m_ptr = 0;
    for (int p = 0; p < NP; p++) m_last[p] = '0;
    drive(0, 1'b1, 1'b0, 16'h0010, '0, '0);
    drive(1, 1'b1, 1'b1, 16'h0010, '0, '1);
    #3;
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_ptr", 64'(dbg_rr_ptr), 64'(0));
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NT; i++) begin
      drive(0, tbl[i].v[0], tbl[i].o[0], tbl[i].a0, tbl[i].d0, tbl[i].be0);
      drive(1, tbl[i].v[1], tbl[i].o[1], tbl[i].a1, tbl[i].d1, tbl[i].be1);
      do_cycle();
      check($sformatf("tbl%0d_ready", i), 64'(s_ready), 64'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_ptr", i), 64'(s_ptr), 64'(tbl[i].e_ptr));
      check($sformatf("tbl%0d_rv", i), 64'(s_rv), 64'(tbl[i].e_rv));
      check($sformatf("tbl%0d_err", i), 64'(s_err), 64'(tbl[i].e_err));
      check($sformatf("tbl%0d_rd0", i), 64'(s_rd[DW-1:0]), 64'(tbl[i].e_rd0));
      check($sformatf("tbl%0d_rd1", i), 64'(s_rd[2*DW-1:DW]), 64'(tbl[i].e_rd1));
    end

    // Reset asserted mid-cycle while a read is in flight.
    drive(0, 1'b1, 1'b0, 16'h0020, '0, '0);
    drive(1, 1'b1, 1'b0, 16'h0030, '0, '0);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_ready", 64'(ready), 64'(0));
    check("midrst_rd_valid", 64'(rd_valid), 64'(0));
    check("midrst_err", 64'(err), 64'(0));
    check("midrst_rd_data", 64'(rd_data), 64'(0));
    check("midrst_ptr", 64'(dbg_rr_ptr), 64'(0));
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    rstn = 1'b1;
    m_ptr = 0;
    for (int p = 0; p < NP; p++) m_last[p] = '0;
    exp_q.delete();
    do_cycle();
    do_cycle();
    drive(0, 1'b1, 1'b0, 16'h0010, '0, '0);
    do_cycle();
    check("post_rst_read", 64'(s_rd[DW-1:0]), 64'(32'hDEADBEAA));
    drive(0, 1'b0, 1'b0, '0, '0, '0);

    // Randomized phase on a small address pool so conflicts are frequent.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b1, AW'(16'h0100 + i), $urandom, '1);
      do_cycle();
    end
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[p]) begin
          int sel;
          logic [AW-1:0] ra;
          sel = $urandom_range(0, 5);
          ra = (sel < 4) ? AW'(16'h0100 + sel) : ((sel == 4) ? 16'hC000 : 16'hFFFF);
          drive(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra,
                $urandom, BW'($urandom_range(0, (1 << BW) - 1)));
        end
      end
      do_cycle();
      pend = valid & ~m_rdy;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
